// File: rtl/collatz_range_par_if.sv
// Host-side bundle of the Collatz range engine: run control, status flags and result read port.
interface collatz_range_par_if #(
  parameter int N_WIDTH       = 32,
  parameter int COUNT_WIDTH   = 16,
  parameter int RAM_ADDR_BITS = 4
) ();
  logic                     go;
  logic [N_WIDTH-1:0]       start;
  logic                     busy;
  logic                     done;
  logic [RAM_ADDR_BITS-1:0] rd_addr;
  logic [COUNT_WIDTH-1:0]   count;
  logic [1:0]               status;

  modport master (output go, start, rd_addr, input busy, done, count, status);
  modport slave  (input go, start, rd_addr, output busy, done, count, status);
endinterface

// File: rtl/collatz_range_par.sv
// Multi-lane Collatz range engine: LANES step datapaths fill a RAM_WORDS-entry result RAM
// with {status,count} for start..start+RAM_WORDS-1, then serve reads with one cycle latency.
module collatz_range_par #(
  parameter int RAM_WORDS     = 16,
  parameter int RAM_ADDR_BITS = 4,
  parameter int N_WIDTH       = 32,
  parameter int COUNT_WIDTH   = 16,
  parameter int LANES         = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  collatz_range_par_if.slave   bus
);
  localparam int                     IW      = RAM_ADDR_BITS + 1;
  localparam int                     EW      = COUNT_WIDTH + 2;
  localparam logic [IW-1:0]          WORDS_C = IW'(RAM_WORDS);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = {COUNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t                   state_q, state_d;
  logic [N_WIDTH-1:0]       base_q, base_d;
  logic [IW-1:0]            index_q, index_d;
  logic [IW-1:0]            wcnt_q, wcnt_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic [COUNT_WIDTH-1:0]   count_q, count_d;
  logic [1:0]               status_q, status_d;

  logic [LANES-1:0]         act_q, act_d;
  logic [LANES-1:0]         fin_q, fin_d;
  logic [N_WIDTH-1:0]       v_q   [LANES];
  logic [N_WIDTH-1:0]       v_d   [LANES];
  logic [COUNT_WIDTH-1:0]   cnt_q [LANES];
  logic [COUNT_WIDTH-1:0]   cnt_d [LANES];
  logic [RAM_ADDR_BITS-1:0] tag_q [LANES];
  logic [RAM_ADDR_BITS-1:0] tag_d [LANES];
  logic [1:0]               st_q  [LANES];
  logic [1:0]               st_d  [LANES];

  logic [EW-1:0]            ram_q [RAM_WORDS];
  logic                     we_s;
  logic [RAM_ADDR_BITS-1:0] waddr_s;
  logic [EW-1:0]            wdata_s;
  logic [LANES-1:0]         ld_oh_s, wr_oh_s;
  logic                     ld_taken_s;
  logic [N_WIDTH+1:0]       tri_s;

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.count  = count_q;
  assign bus.status = status_q;

  // Lowest finished lane owns the write port; lowest idle lane takes the next index.
  always_comb begin
    ld_oh_s    = '0;
    wr_oh_s    = '0;
    ld_taken_s = 1'b0;
    we_s       = 1'b0;
    waddr_s    = '0;
    wdata_s    = '0;
    for (int i = 0; i < LANES; i++) begin
      if (state_q == S_RUN && !we_s && fin_q[i]) begin
        we_s       = 1'b1;
        wr_oh_s[i] = 1'b1;
        waddr_s    = tag_q[i];
        wdata_s    = {st_q[i], cnt_q[i]};
      end else begin
        wr_oh_s[i] = 1'b0;
      end
      if (state_q == S_RUN && !ld_taken_s && !act_q[i] && index_q < WORDS_C) begin
        ld_taken_s = 1'b1;
        ld_oh_s[i] = 1'b1;
      end else begin
        ld_oh_s[i] = 1'b0;
      end
    end
  end

  // Per-lane load / one Collatz step / finish; a written lane drops back to idle.
  always_comb begin
    act_d = act_q;
    fin_d = fin_q;
    v_d   = v_q;
    cnt_d = cnt_q;
    tag_d = tag_q;
    st_d  = st_q;
    tri_s = '0;
    for (int i = 0; i < LANES; i++) begin
      tri_s = {2'b00, v_q[i]} + {1'b0, v_q[i], 1'b0} + (N_WIDTH+2)'(1);
      if (wr_oh_s[i]) begin
        act_d[i] = 1'b0;
        fin_d[i] = 1'b0;
      end else if (ld_oh_s[i]) begin
        act_d[i] = 1'b1;
        fin_d[i] = 1'b0;
        v_d[i]   = base_q + N_WIDTH'(index_q);
        cnt_d[i] = COUNT_WIDTH'(1);
        tag_d[i] = index_q[RAM_ADDR_BITS-1:0];
      end else if (act_q[i] && !fin_q[i]) begin
        if (v_q[i] == N_WIDTH'(0)) begin
          fin_d[i] = 1'b1;
          cnt_d[i] = COUNT_WIDTH'(0);
          st_d[i]  = 2'b11;
        end else if (v_q[i] == N_WIDTH'(1)) begin
          fin_d[i] = 1'b1;
          st_d[i]  = 2'b00;
        end else if (cnt_q[i] == CNT_MAX) begin
          fin_d[i] = 1'b1;
          st_d[i]  = 2'b01;
        end else if (v_q[i][0] && tri_s[N_WIDTH+1:N_WIDTH] != 2'b00) begin
          fin_d[i] = 1'b1;
          st_d[i]  = 2'b10;
        end else begin
          v_d[i]   = v_q[i][0] ? tri_s[N_WIDTH-1:0] : (v_q[i] >> 1);
          cnt_d[i] = cnt_q[i] + COUNT_WIDTH'(1);
        end
      end else begin
        act_d[i] = act_q[i];
      end
    end
  end

  // Run control and the registered read port.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    index_d  = index_q;
    wcnt_d   = wcnt_q;
    busy_d   = busy_q;
    done_d   = done_q;
    count_d  = COUNT_WIDTH'(0);
    status_d = 2'b00;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.go) begin
          state_d = S_RUN;
          base_d  = bus.start;
          index_d = IW'(0);
          wcnt_d  = IW'(0);
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      S_RUN: begin
        if (ld_taken_s) begin
          index_d = index_q + IW'(1);
        end else begin
          index_d = index_q;
        end
        if (we_s) begin
          wcnt_d = wcnt_q + IW'(1);
          if (wcnt_d == WORDS_C) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          wcnt_d = wcnt_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
    if (done_q && {1'b0, bus.rd_addr} < WORDS_C) begin
      {status_d, count_d} = ram_q[bus.rd_addr];
    end else begin
      count_d  = COUNT_WIDTH'(0);
      status_d = 2'b00;
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      base_q   <= N_WIDTH'(0);
      index_q  <= IW'(0);
      wcnt_q   <= IW'(0);
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      count_q  <= COUNT_WIDTH'(0);
      status_q <= 2'b00;
      act_q    <= '0;
      fin_q    <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      index_q  <= index_d;
      wcnt_q   <= wcnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      count_q  <= count_d;
      status_q <= status_d;
      act_q    <= act_d;
      fin_q    <= fin_d;
    end
  end

  // Lane datapath payload is only meaningful while the lane is active, so it is not reset.
  always_ff @(posedge clk) begin
    v_q   <= v_d;
    cnt_q <= cnt_d;
    tag_q <= tag_d;
    st_q  <= st_d;
  end

  // Result RAM keeps its contents across reset; a reset cycle blocks the write.
  always_ff @(posedge clk) begin
    if (we_s && !reset) begin
      ram_q[waddr_s] <= wdata_s;
    end
  end
endmodule
